// File: rtl/test_end_monitor.sv
// test_end_monitor: end-of-test monitor for the core/TCM subsystem.
// Counts cycles and retired instructions, ends the test after HIT_COUNT
// retirements of TOHOST_PC, then judges pass by x3 (SIG_MODE=0) or by
// streaming a signature region from data memory and comparing it against a
// registered reference ROM (SIG_MODE=1). Reports done/pass/timeout.
// Ports: clk/rstz (async active-low); retire_* and x3_val tap the core;
// cfg_sig_* describe the signature region; mem_* is a spare TCM read port;
// ref_* reads the reference ROM; done/pass/timeout/fail_index/cycle_cnt/
// instret_cnt are registered results.
module test_end_monitor #(
  parameter logic [31:0] TOHOST_PC      = 32'h80000086,
  parameter int          HIT_COUNT      = 8,
  parameter int          CNT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          SIG_MODE       = 0,
  parameter int          SIG_AW         = 10
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic              retire_valid,
  input  logic [31:0]       retire_pc,
  input  logic [31:0]       x3_val,
  input  logic [31:0]       cfg_sig_base,
  input  logic [SIG_AW:0]   cfg_sig_words,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdat,
  output logic [SIG_AW-1:0] ref_addr,
  input  logic [31:0]       ref_rdat,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [SIG_AW-1:0] fail_index,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_SIG_REQ  = 2'd1;
  localparam logic [1:0] S_SIG_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        HIT_LAST = 8'(HIT_COUNT - 1);
  localparam logic [SIG_AW-1:0] IDX_ONE  = SIG_AW'(1);
  localparam logic [SIG_AW:0]   WRD_ONE  = (SIG_AW+1)'(1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic [SIG_AW-1:0] idx_q, idx_d, idx_n;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instret_cnt_q, instret_cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [SIG_AW-1:0] fail_index_q, fail_index_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              in_run, hit, final_hit, last_word;

  assign in_run    = state_q == S_RUN;
  assign hit       = retire_valid && retire_pc == TOHOST_PC;
  assign final_hit = in_run && hit && hit_cnt_q == HIT_LAST;
  assign idx_n     = idx_q + IDX_ONE;
  assign last_word = {1'b0, idx_q} == cfg_sig_words - WRD_ONE;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_index_d  = fail_index_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    cycle_cnt_d   = (state_q != S_DONE && cycle_cnt_q != CNT_MAX) ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;
    instret_cnt_d = (in_run && retire_valid && instret_cnt_q != CNT_MAX) ? instret_cnt_q + CNT_ONE : instret_cnt_q;
    hit_cnt_d     = (in_run && hit && hit_cnt_q != 8'hff) ? hit_cnt_q + 8'd1 : hit_cnt_q;
    case (state_q)
      S_RUN: begin
        // A completing hit takes priority over a timeout in the same cycle.
        if (final_hit) begin
          if (SIG_MODE == 0) begin
            state_d = S_DONE;
            pass_d  = x3_val == 32'd1;
          end else if (cfg_sig_words == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d    = S_SIG_REQ;
            idx_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = cfg_sig_base;
          end
        end else if (cycle_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      S_SIG_REQ: state_d = S_SIG_WAIT;
      S_SIG_WAIT: begin
        if (mem_ack) begin
          if (mem_rdat != ref_rdat) begin
            state_d      = S_DONE;
            fail_index_d = idx_q;
            pass_d       = 1'b0;
            mem_req_d    = 1'b0;
          end else if (last_word) begin
            state_d   = S_DONE;
            pass_d    = 1'b1;
            mem_req_d = 1'b0;
          end else begin
            // Request stays high into the next word with the new address.
            state_d    = S_SIG_REQ;
            idx_d      = idx_n;
            mem_addr_d = cfg_sig_base + (32'(idx_n) << 2);
          end
        end
      end
      default: ;
    endcase
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q       <= S_RUN;
      hit_cnt_q     <= '0;
      idx_q         <= '0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_index_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      hit_cnt_q     <= hit_cnt_d;
      idx_q         <= idx_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_index_q  <= fail_index_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign ref_addr    = idx_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_index  = fail_index_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
endmodule
